data_mem_responder: RTL and testbench

- Responder (memory) side of the CPU load/store interface.
- Accepts one request at a time from the multicycle CPU and services it from an internal byte-addressable, little-endian store of 64-bit words.
- Models configurable wait states, performs read-modify-write for sub-doubleword stores, and returns sign/zero-extended load data.
- Flags misaligned and out-of-range accesses.

---
 rtl/data_mem_responder.sv | 188 ++++++++++++++++++
 tb/tb_data_mem_responder.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Memory-side responder for the CPU load/store port: byte-addressed little-endian 64-bit store.
// Latency: WAIT_CYCLES+1 cycles for loads/double stores, +2 for sub-doubleword stores, 1 cycle for errors.
// Backpressure: one request in flight; response held in RESP until rsp_ready, req_ready only in IDLE.
module data_mem_responder #(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, MERGE, RESP} state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          we_q, we_d;
    logic [1:0]    size_q, size_d;
    logic          uns_q, uns_d;
    logic [AW+2:0] addr_q, addr_d;
    logic [63:0]   wdata_q, wdata_d;
    logic [63:0]   old_q, old_d;
    logic [63:0]   rdata_q, rdata_d;
    logic          err_q, err_d;

    logic [63:0]   mem [DEPTH];
    logic          mem_we;
    logic [63:0]   mem_wdat;
    logic [AW-1:0] idx;
    logic [63:0]   rd_word, shifted, load_ext, wsh, merged;
    logic [7:0]    lane_mask;
    logic          misaligned, out_of_range;

    assign idx     = addr_q[AW+2:3];
    assign rd_word = mem[idx];
    assign shifted = rd_word >> {addr_q[2:0], 3'b000};
    assign wsh     = wdata_q << {addr_q[2:0], 3'b000};

    always_comb begin
        misaligned = 1'b0;
        case (req_size)
            2'd0: misaligned = 1'b0;
            2'd1: misaligned = req_addr[0];
            2'd2: misaligned = |req_addr[1:0];
            2'd3: misaligned = |req_addr[2:0];
            default: misaligned = 1'b0;
        endcase
        out_of_range = (req_addr[63:3] >= 61'(DEPTH));
    end

    // Extension fill bit is forced to 0 for unsigned loads.
    always_comb begin
        load_ext  = shifted;
        lane_mask = 8'hFF;
        case (size_q)
            2'd0: begin
                load_ext  = {{56{~uns_q & shifted[7]}}, shifted[7:0]};
                lane_mask = 8'h01 << addr_q[2:0];
            end
            2'd1: begin
                load_ext  = {{48{~uns_q & shifted[15]}}, shifted[15:0]};
                lane_mask = 8'h03 << addr_q[2:0];
            end
            2'd2: begin
                load_ext  = {{32{~uns_q & shifted[31]}}, shifted[31:0]};
                lane_mask = 8'h0F << addr_q[2:0];
            end
            default: begin
                load_ext  = shifted;
                lane_mask = 8'hFF;
            end
        endcase
        for (int i = 0; i < 8; i++) begin
            merged[8*i +: 8] = lane_mask[i] ? wsh[8*i +: 8] : old_q[8*i +: 8];
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        size_d   = size_q;
        uns_d    = uns_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        old_d    = old_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        mem_we   = 1'b0;
        mem_wdat = wdata_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    addr_d  = req_addr[AW+2:0];
                    wdata_d = req_wdata;
                    rdata_d = 64'd0;
                    if (misaligned || out_of_range) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        err_d   = 1'b0;
                        cnt_d   = 4'(WAIT_CYCLES - 1);
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else if (!we_q) begin
                    rdata_d = load_ext;
                    state_d = RESP;
                end else if (size_q == 2'd3) begin
                    mem_we  = 1'b1;
                    state_d = RESP;
                end else begin
                    old_d   = rd_word;
                    state_d = MERGE;
                end
            end
            MERGE: begin
                mem_we   = 1'b1;
                mem_wdat = merged;
                state_d  = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rdata_d = 64'd0;
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            size_q  <= 2'd0;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 64'd0;
            old_q   <= 64'd0;
            rdata_q <= 64'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            old_q   <= old_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Store contents survive reset; writes are gated by state, which reset forces to IDLE.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[idx] <= mem_wdat;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder with DEPTH=256, WAIT_CYCLES=2.
module tb_data_mem_responder;
    logic        clock = 1'b0;
    logic        reset_n;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [63:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [63:0] rsp_rdata;

    int checks = 0;
    int errors = 0;

    data_mem_responder #(.DEPTH(256), .WAIT_CYCLES(2)) dut (
        .clock(clock), .reset(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    always #5 clock = ~clock;

    // Issue one request; lat counts cycles from accept edge to first rsp_valid (1 = cycle after accept).
    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [63:0] addr, input logic [63:0] wdata,
                          output int lat, output logic [63:0] rdata, output logic err);
        req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1;
        @(posedge clock); #1;
        req_valid = 1'b0;
        req_addr  = 64'hFFFF_FFFF_FFFF_FFFF;
        req_wdata = 64'h5555_5555_5555_5555;
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            @(posedge clock); #1;
            lat++;
        end
        rdata = rsp_rdata;
        err   = rsp_err;
        if (rsp_ready && rsp_valid) begin
            @(posedge clock); #1;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1; req_we = 1'b0;
        req_size = 2'd0; req_unsigned = 1'b0; req_addr = 64'd0; req_wdata = 64'd0;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        checks++; if (rsp_rdata !== 64'd0) begin errors++; $display("FAIL reset_rsp_rdata got=%h exp=0", rsp_rdata); end
        checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err got=%b exp=0", rsp_err); end
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
    endtask

    task automatic test_double_store_load();
        int lat; logic [63:0] d; logic e;
        do_req(1'b1, 2'd3, 1'b0, 64'h10, 64'hDEADBEEF_CAFEF00D, lat, d, e);
        checks++; if (lat !== 3) begin errors++; $display("FAIL dstore_latency got=%0d exp=3", lat); end
        checks++; if (e !== 1'b0 || d !== 64'd0) begin errors++; $display("FAIL dstore_rsp got err=%b data=%h exp err=0 data=0", e, d); end
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL dstore_release got valid=%b ready=%b exp 0/1", rsp_valid, req_ready); end
        do_req(1'b0, 2'd3, 1'b0, 64'h10, 64'd0, lat, d, e);
        checks++; if (lat !== 3) begin errors++; $display("FAIL dload_latency got=%0d exp=3", lat); end
        checks++; if (d !== 64'hDEADBEEF_CAFEF00D || e !== 1'b0) begin errors++; $display("FAIL dload_data got=%h err=%b exp=deadbeefcafef00d err=0", d, e); end
        checks++; if (rsp_rdata !== 64'd0) begin errors++; $display("FAIL dload_clear got=%h exp=0", rsp_rdata); end
    endtask

    task automatic test_subword_rmw();
        int lat; logic [63:0] d; logic e;
        do_req(1'b1, 2'd0, 1'b0, 64'h13, 64'hFFFF_FFFF_FFFF_FF80, lat, d, e);
        checks++; if (lat !== 4) begin errors++; $display("FAIL bstore_latency got=%0d exp=4", lat); end
        checks++; if (e !== 1'b0 || d !== 64'd0) begin errors++; $display("FAIL bstore_rsp got err=%b data=%h exp err=0 data=0", e, d); end
        do_req(1'b0, 2'd3, 1'b0, 64'h10, 64'd0, lat, d, e);
        checks++; if (d !== 64'hDEADBEEF_80FEF00D) begin errors++; $display("FAIL rmw_result got=%h exp=deadbeef80fef00d", d); end
    endtask

    task automatic test_extension();
        int lat; logic [63:0] d; logic e;
        do_req(1'b0, 2'd0, 1'b0, 64'h13, 64'd0, lat, d, e);
        checks++; if (d !== 64'hFFFFFFFF_FFFFFF80) begin errors++; $display("FAIL sbyte got=%h exp=ffffffffffffff80", d); end
        do_req(1'b0, 2'd0, 1'b1, 64'h13, 64'd0, lat, d, e);
        checks++; if (d !== 64'h00000000_00000080) begin errors++; $display("FAIL ubyte got=%h exp=0000000000000080", d); end
        do_req(1'b0, 2'd1, 1'b0, 64'h14, 64'd0, lat, d, e);
        checks++; if (d !== 64'hFFFFFFFF_FFFFBEEF) begin errors++; $display("FAIL shalf got=%h exp=ffffffffffffbeef", d); end
        do_req(1'b0, 2'd2, 1'b1, 64'h14, 64'd0, lat, d, e);
        checks++; if (d !== 64'h00000000_DEADBEEF) begin errors++; $display("FAIL uword got=%h exp=00000000deadbeef", d); end
        do_req(1'b0, 2'd2, 1'b0, 64'h10, 64'd0, lat, d, e);
        checks++; if (d !== 64'hFFFFFFFF_80FEF00D) begin errors++; $display("FAIL sword got=%h exp=ffffffff80fef00d", d); end
    endtask

    task automatic test_errors();
        int lat; logic [63:0] d; logic e;
        do_req(1'b0, 2'd2, 1'b0, 64'h12, 64'd0, lat, d, e);
        checks++; if (lat !== 1) begin errors++; $display("FAIL misalign_latency got=%0d exp=1", lat); end
        checks++; if (e !== 1'b1 || d !== 64'd0) begin errors++; $display("FAIL misalign_rsp got err=%b data=%h exp err=1 data=0", e, d); end
        do_req(1'b1, 2'd3, 1'b0, 64'h0, 64'h01234567_89ABCDEF, lat, d, e);
        do_req(1'b1, 2'd3, 1'b0, 64'h800, 64'h1111_2222_3333_4444, lat, d, e);
        checks++; if (lat !== 1 || e !== 1'b1) begin errors++; $display("FAIL oor_rsp got lat=%0d err=%b exp lat=1 err=1", lat, e); end
        do_req(1'b0, 2'd3, 1'b0, 64'h10, 64'd0, lat, d, e);
        checks++; if (d !== 64'hDEADBEEF_80FEF00D) begin errors++; $display("FAIL oor_mem10 got=%h exp=deadbeef80fef00d", d); end
        do_req(1'b0, 2'd3, 1'b0, 64'h0, 64'd0, lat, d, e);
        checks++; if (d !== 64'h01234567_89ABCDEF) begin errors++; $display("FAIL oor_mem0 got=%h exp=0123456789abcdef", d); end
    endtask

    task automatic test_backpressure();
        int lat; logic [63:0] d; logic e;
        rsp_ready = 1'b0;
        do_req(1'b0, 2'd3, 1'b0, 64'h10, 64'd0, lat, d, e);
        checks++; if (d !== 64'hDEADBEEF_80FEF00D) begin errors++; $display("FAIL bp_data got=%h exp=deadbeef80fef00d", d); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== 64'hDEADBEEF_80FEF00D || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cyc=%0d got valid=%b data=%h ready=%b exp 1/deadbeef80fef00d/0", i, rsp_valid, rsp_rdata, req_ready);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clock); #1;
        checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 64'd0) begin errors++; $display("FAIL bp_release got ready=%b valid=%b data=%h exp 1/0/0", req_ready, rsp_valid, rsp_rdata); end
    endtask

    task automatic test_reset_abort();
        int lat; logic [63:0] d; logic e;
        do_req(1'b1, 2'd3, 1'b0, 64'h20, 64'h11223344_55667788, lat, d, e);
        req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0; req_addr = 64'h21; req_wdata = 64'hAA;
        req_valid = 1'b1;
        @(posedge clock); #1;
        req_valid = 1'b0;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL abort_accepted got ready=%b exp=0", req_ready); end
        #1 reset_n = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 64'd0 || rsp_err !== 1'b0) begin
            errors++; $display("FAIL abort_outputs got ready=%b valid=%b data=%h err=%b exp 1/0/0/0", req_ready, rsp_valid, rsp_rdata, rsp_err);
        end
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;
        do_req(1'b0, 2'd3, 1'b0, 64'h20, 64'd0, lat, d, e);
        checks++; if (lat !== 3) begin errors++; $display("FAIL abort_next_latency got=%0d exp=3", lat); end
        checks++; if (d !== 64'h11223344_55667788) begin errors++; $display("FAIL abort_mem got=%h exp=1122334455667788", d); end
    endtask

    task automatic test_back_to_back();
        int lat; logic [63:0] d; logic e;
        do_req(1'b1, 2'd1, 1'b0, 64'h26, 64'h0000_0000_0000_CDEF, lat, d, e);
        checks++; if (lat !== 4) begin errors++; $display("FAIL hstore_latency got=%0d exp=4", lat); end
        do_req(1'b0, 2'd3, 1'b0, 64'h20, 64'd0, lat, d, e);
        checks++; if (d !== 64'hCDEF3344_55667788) begin errors++; $display("FAIL hstore_result got=%h exp=cdef334455667788", d); end
    endtask

    initial begin
        test_reset();
        test_double_store_load();
        test_subword_rmw();
        test_extension();
        test_errors();
        test_backpressure();
        test_reset_abort();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
